conv_last_to_first_with_ready: RTL and testbench



---
 rtl/stream_conv_pkg.sv | 32 +++
 rtl/stream_fifo_2.sv | 95 +++++++++
 rtl/conv_last_to_first_with_ready.sv | 101 ++++++++++
 tb/tb_conv_last_to_first_with_ready.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_conv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : stream_conv_pkg
// Description : Shared types and constants for the last-to-first stream
//               converter.
//               - tag_t            : per-beat framing flags in a buffer entry
//               - EXPECT_FIRST_RST : reset value of the expect_first register
//               - entry_w()        : packed buffer-entry width for a given
//                                    data and index width
// Revision    : 1.0 - initial release
// ============================================================================
package stream_conv_pkg;

  // After reset the next accepted beat always opens a new packet.
  localparam logic EXPECT_FIRST_RST = 1'b1;

  // Framing flags carried alongside data and index in every buffer entry.
  typedef struct packed {
    logic first;
    logic last;
    logic err;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // A buffer entry is packed as {data, index, tag}.
  function automatic int entry_w(input int data_w, input int idx_w);
    return data_w + idx_w + TAG_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_fifo_2.sv
`default_nettype none
// ============================================================================
// Module      : stream_fifo_2
// Description : Two-entry valid/ready FIFO, generic over payload width.
//               It is built as a head register plus one skid register, so
//               the output is always driven straight from a flop.
//               in_ready depends on registered state only.
// Ports       : clock     - rising-edge clock
//               reset     - asynchronous, active-low
//               in_valid  / in_ready  / in_data  - write side
//               out_valid / out_ready / out_data - read side (head entry)
// Revision    : 1.0 - initial release
// ============================================================================
module stream_fifo_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  // Holds in_ready low during reset and sets on the first edge after release.
  logic             ready_en_q, ready_en_d;

  logic push;
  logic pop;

  assign in_ready  = ready_en_q && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    ready_en_d = 1'b1;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // The pushed beat becomes the new head immediately: no bubble.
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          // head_q keeps its old contents; it is don't-care while empty.
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      ready_en_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_last_to_first_with_ready.sv
`default_nettype none
// ============================================================================
// Module      : conv_last_to_first_with_ready
// Description : Converts a last-framed valid/ready stream into a first-framed
//               one. Each beat is tagged at acceptance with first, a zero-based
//               index, and a truncation flag. Packets reaching max_len beats
//               without last are forcibly closed with err set. Beats pass
//               through a 2-entry FIFO, which sustains one beat per clock.
//               max_len must be at least 2.
// Ports       : clock, reset (async active-low)
//               up_valid / up_ready / up_last / up_data     - source side
//               down_valid / down_ready / down_first / down_last /
//               down_data / down_index / down_err             - sink side
// Revision    : 1.0 - initial release
// ============================================================================
module conv_last_to_first_with_ready
  import stream_conv_pkg::*;
#(
  parameter int width   = 8,
  parameter int max_len = 16,
  parameter int index_w = $clog2(max_len)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic               up_last,
  input  logic [width-1:0]   up_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic               down_first,
  output logic               down_last,
  output logic [width-1:0]   down_data,
  output logic [index_w-1:0] down_index,
  output logic               down_err
);

  localparam int                 ENTRY_W  = entry_w(width, index_w);
  localparam logic [index_w-1:0] LAST_IDX = index_w'(max_len - 1);

  logic               expect_first_q, expect_first_d;
  logic [index_w-1:0] index_q, index_d;

  logic               accept;
  logic [index_w-1:0] beat_idx;
  tag_t               in_tag;
  tag_t               out_tag;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] out_entry;

  assign accept = up_valid && up_ready;

  // Input-side tagging. index_q holds the index of the last accepted beat.
  always_comb begin
    beat_idx     = expect_first_q ? '0 : index_q + 1'b1;
    in_tag.first = expect_first_q;
    // Close the packet at the length limit unless the source already did.
    in_tag.err   = (beat_idx == LAST_IDX) && !up_last;
    in_tag.last  = up_last || in_tag.err;
    in_entry     = {up_data, beat_idx, in_tag};

    expect_first_d = expect_first_q;
    index_d        = index_q;
    if (accept) begin
      expect_first_d = in_tag.last;
      index_d        = beat_idx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      expect_first_q <= EXPECT_FIRST_RST;
      index_q        <= '0;
    end else begin
      expect_first_q <= expect_first_d;
      index_q        <= index_d;
    end
  end

  stream_fifo_2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (up_valid),
    .in_ready  (up_ready),
    .in_data   (in_entry),
    .out_valid (down_valid),
    .out_ready (down_ready),
    .out_data  (out_entry)
  );

  always_comb begin
    {down_data, down_index, out_tag} = out_entry;
    down_first = out_tag.first;
    down_last  = out_tag.last;
    down_err   = out_tag.err;
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_last_to_first_with_ready.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_last_to_first_with_ready
// Description : Self-checking bench for conv_last_to_first_with_ready with
//               max_len = 4. Expected beats are queued when a beat is
//               accepted and compared when the sink consumes a beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_last_to_first_with_ready;

  localparam int W   = 8;
  localparam int ML  = 4;
  localparam int IW  = 2;

  logic          clock;
  logic          reset;
  logic          up_valid;
  logic          up_ready;
  logic          up_last;
  logic [W-1:0]  up_data;
  logic          down_valid;
  logic          down_ready;
  logic          down_first;
  logic          down_last;
  logic [W-1:0]  down_data;
  logic [IW-1:0] down_index;
  logic          down_err;

  conv_last_to_first_with_ready #(
    .width   (W),
    .max_len (ML),
    .index_w (IW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_last    (up_last),
    .up_data    (up_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_first (down_first),
    .down_last  (down_last),
    .down_data  (down_data),
    .down_index (down_index),
    .down_err   (down_err)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          last;
    logic          first_e;
    logic          last_e;
    logic          err_e;
    logic [IW-1:0] idx_e;
  } vec_t;

  typedef struct {
    logic [W-1:0]  data;
    logic          first;
    logic          last;
    logic          err;
    logic [IW-1:0] idx;
    int            acc_cyc;
    bit            lat;
  } exp_t;

  vec_t  tbl [11];
  exp_t  sbq [$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  logic  m_ef = 1'b1;
  logic [IW-1:0] m_idx = '0;
  bit    rand_done = 0;
  bit    drv_done = 0;
  bit    stalled = 0;
  logic [12:0] prev_out = '0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [12:0] pk(input exp_t e);
    return {e.data, e.first, e.last, e.err, e.idx};
  endfunction

  function automatic exp_t tv(input int i, input bit lat);
    exp_t e;
    e.data = tbl[i].data;  e.first = tbl[i].first_e; e.last = tbl[i].last_e;
    e.err = tbl[i].err_e;  e.idx = tbl[i].idx_e;     e.acc_cyc = 0; e.lat = lat;
    return e;
  endfunction

  // Reference tagging for random traffic.
  function automatic exp_t model(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.data  = d;
    e.first = m_ef;
    e.idx   = m_ef ? 2'd0 : m_idx + 2'd1;
    e.err   = (e.idx == 2'd3) && !l;
    e.last  = l || e.err;
    e.acc_cyc = 0;
    e.lat   = 1'b0;
    m_ef    = e.last;
    m_idx   = e.idx;
    return e;
  endfunction

  // Offer one beat; queue its expectation once acceptance is certain.
  task automatic send(input logic [W-1:0] d, input logic l, input exp_t e);
    int n = 0;
    up_valid = 1'b1; up_data = d; up_last = l;
    do begin
      @(negedge clock);
      n++;
    end while (!up_ready && n < 1000);
    if (!up_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: up_ready stayed 0, required 1");
    end else begin
      e.acc_cyc = cyc + 1;
      sbq.push_back(e);
      acc_cnt++;
    end
    @(posedge clock); #1;
    up_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    up_valid = 1'b0;
    #1;
    sbq.delete();
    m_ef = 1'b1; m_idx = '0; acc_cnt = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("drain_queue", 32'(sbq.size()), 32'd0);
    @(posedge clock); #1;
    chk("empty_after_drain", 32'(down_valid), 32'd0);
  endtask

  // Sink-side monitor: compare consumed beats and stall stability.
  always @(negedge clock) begin
    logic [12:0] cur;
    exp_t e;
    cur = {down_data, down_first, down_last, down_err, down_index};
    if (!reset) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_stable", 32'(cur), 32'(prev_out));
      if (down_valid && down_ready) begin
        if (sbq.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_beat: got beat %0h, required none", cur);
        end else begin
          e = sbq.pop_front();
          chk("beat", 32'(cur), 32'(pk(e)));
          if (e.lat) chk("latency", 32'(cyc + 1), 32'(e.acc_cyc + 1));
        end
      end
      stalled  = down_valid && !down_ready;
      prev_out = cur;
    end
  end

  initial begin
    exp_t e;
    //              data  last first last err idx
    tbl[0]  = '{8'hA0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{8'hA1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[2]  = '{8'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[3]  = '{8'hB0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{8'h10, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[5]  = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[6]  = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2};
    tbl[7]  = '{8'h13, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3};
    tbl[8]  = '{8'h14, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    tbl[9]  = '{8'h15, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1};
    tbl[10] = '{8'hC2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0};

    reset = 1'b0; up_valid = 1'b0; up_last = 1'b0; up_data = '0; down_ready = 1'b1;

    // Reset values, then up_ready rising only at the first edge after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_down_first", 32'(down_first), 32'd0);
    chk("rst_down_last",  32'(down_last),  32'd0);
    chk("rst_down_err",   32'(down_err),   32'd0);
    chk("rst_down_data",  32'(down_data),  32'd0);
    chk("rst_down_index", 32'(down_index), 32'd0);
    chk("rst_up_ready",   32'(up_ready),   32'd0);
    reset = 1'b1;
    #1;
    chk("up_ready_before_edge", 32'(up_ready), 32'd0);
    @(posedge clock); #1;
    chk("up_ready_after_edge", 32'(up_ready), 32'd1);

    // Back-to-back packets with the sink always ready.
    for (int i = 0; i < 4; i++) send(tbl[i].data, tbl[i].last, tv(i, 1'b1));
    drain();

    // Same stream with the sink stalled for five cycles.
    do_reset();
    down_ready = 1'b0;
    drv_done = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(tbl[i].data, tbl[i].last, tv(i, 1'b0));
        drv_done = 1;
      end
    join_none
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      if (k >= 3) chk("full_up_ready", 32'(up_ready), 32'd0);
    end
    chk("stall_accepted", 32'(acc_cnt), 32'd2);
    down_ready = 1'b1;
    @(negedge clock);
    chk("ready_after_pop", 32'(up_ready), 32'd1);
    begin
      int n = 0;
      while (!drv_done && n < 200) begin @(negedge clock); n++; end
      chk("stall_driver_done", 32'(drv_done), 32'd1);
    end
    drain();

    // A packet longer than max_len without last.
    do_reset();
    down_ready = 1'b1;
    for (int i = 4; i < 10; i++) send(tbl[i].data, tbl[i].last, tv(i, 1'b1));
    drain();

    // Random source gaps and sink back-pressure.
    do_reset();
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          down_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int b = 0; b < 10000; b++) begin
      logic [W-1:0] d;
      logic         l;
      if ($urandom_range(0, 1) == 1) begin
        up_valid = 1'b0;
        @(posedge clock); #1;
      end
      d = 8'($urandom_range(0, 255));
      l = ($urandom_range(0, 3) == 0);
      e = model(d, l);
      send(d, l, e);
    end
    rand_done = 1;
    @(posedge clock); #2;
    down_ready = 1'b1;
    drain();

    // Reset with two beats of an open packet buffered.
    do_reset();
    down_ready = 1'b0;
    e = model(8'hC0, 1'b0); send(8'hC0, 1'b0, e);
    e = model(8'hC1, 1'b0); send(8'hC1, 1'b0, e);
    @(negedge clock);
    chk("pre_reset_valid", 32'(down_valid), 32'd1);
    chk("pre_reset_full",  32'(up_ready),   32'd0);
    reset = 1'b0;
    #1;
    chk("reset_drops_valid", 32'(down_valid), 32'd0);
    chk("reset_drops_ready", 32'(up_ready),   32'd0);
    sbq.delete();
    m_ef = 1'b1; m_idx = '0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    down_ready = 1'b1;
    send(tbl[10].data, tbl[10].last, tv(10, 1'b1));
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
